// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with an optional skid entry, a sticky halt flag
// and a saturating downstream bubble counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] skid_data;
  logic              skid_halt;
  logic              rdy_q;
  logic              halted_nx;
  logic              acc;
  logic              deq;

  assign out_valid = en & (state != EMPTY);
  assign occ       = 2'(state);

  // Skid build: ready comes from a register, never from out_ready.
  assign in_ready = (SKID_EN != 0) ? (rdy_q & en & ~flush)
                                   : (en & ~halted & ~flush & (~out_valid | out_ready));

  assign acc = in_valid & in_ready;
  assign deq = out_valid & out_ready & ~flush;

  // Next occupancy and halt flag; flush wins over accept and dequeue.
  always_comb begin
    state_nx  = state;
    halted_nx = halted;
    if (en) begin
      if (deq && out_halt) halted_nx = 1'b1;
      if (flush) begin
        state_nx = EMPTY;
      end else begin
        case (state)
          EMPTY: if (acc) state_nx = ONE;
          ONE: begin
            if (acc && !deq)      state_nx = TWO;
            else if (!acc && deq) state_nx = EMPTY;
          end
          TWO:     if (deq) state_nx = ONE;
          default: state_nx = EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= EMPTY;
      rdy_q      <= 1'b0;
      halted     <= 1'b0;
      bubble_cnt <= '0;
      out_data   <= '0;
      out_halt   <= 1'b0;
      skid_data  <= '0;
      skid_halt  <= 1'b0;
    end else if (en) begin
      state  <= state_nx;
      halted <= halted_nx;
      rdy_q  <= (state_nx != TWO) & ~halted_nx;
      if (out_ready && !out_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      // Head loads directly when empty or when draining in the same cycle.
      if (!flush) begin
        if (acc && (state == EMPTY || deq)) begin
          out_data <= in_data;
          out_halt <= in_halt;
        end else if (acc) begin
          skid_data <= in_data;
          skid_halt <= in_halt;
        end else if (deq && state == TWO) begin
          out_data <= skid_data;
          out_halt <= skid_halt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: directed vector table, corner sequences and a random
// run against a queue model, for both the skid and single-entry builds.
module tb_pipe_stage_skid;

  logic        CLK;
  logic        nRST;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_halt;
  logic        out_ready;

  logic        ir [2];
  logic        ov [2];
  logic [15:0] od [2];
  logic        oh [2];
  logic        hl [2];
  logic [1:0]  oc [2];
  logic [3:0]  bc [2];

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(16), .SKID_EN(1), .CNT_W(4)) u_skid (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_halt(in_halt),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_halt(oh[0]),
    .halted(hl[0]), .occ(oc[0]), .bubble_cnt(bc[0])
  );

  pipe_stage_skid #(.DATA_W(16), .SKID_EN(0), .CNT_W(4)) u_single (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_halt(in_halt),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_halt(oh[1]),
    .halted(hl[1]), .occ(oc[1]), .bubble_cnt(bc[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic e, input logic f, input logic v,
                       input logic [15:0] d, input logic h, input logic o);
    @(negedge CLK);
    nRST = r; en = e; flush = f; in_valid = v; in_data = d; in_halt = h; out_ready = o;
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_occ;
    logic [3:0]  e_bub;
  } vec_t;

  vec_t tbl [11];

  // Reference model: per instance a small FIFO of {halt, data}.
  logic [16:0] mb [2][2];
  int          mc [2];
  bit          mh [2];
  int          mbub [2];
  bit          mst [2];
  bit          m_acc [2];
  bit          m_deq [2];
  bit          m_ov [2];

  initial begin
    nRST = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_halt = 1'b0; out_ready = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h1, 1'b1, 1'b1, 1'b0, 16'h0, 2'd0, 4'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h2, 1'b1, 1'b1, 1'b1, 16'h1, 2'd1, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h3, 1'b1, 1'b1, 1'b1, 16'h2, 2'd1, 4'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h3, 2'd1, 4'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'hA, 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 4'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 16'hB, 1'b0, 1'b1, 1'b1, 16'hA, 2'd1, 4'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'hC, 1'b0, 1'b0, 1'b1, 16'hA, 2'd2, 4'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'hA, 2'd2, 4'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'hB, 2'd1, 4'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 4'd1};

    // Reset state
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_occ", 32'(oc[0]), 0);
    check("rst_in_ready", 32'(ir[0]), 0);
    check("rst_out_valid", 32'(ov[0]), 0);
    check("rst_out_data", 32'(od[0]), 0);
    check("rst_out_halt", 32'(oh[0]), 0);
    check("rst_halted", 32'(hl[0]), 0);
    check("rst_bubble", 32'(bc[0]), 0);

    // Back-to-back flow and backpressure
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].en, tbl[i].flush, tbl[i].in_valid, tbl[i].in_data, 1'b0,
            tbl[i].out_ready);
      check($sformatf("vec%0d_in_ready", i), 32'(ir[0]), 32'(tbl[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), 32'(ov[0]), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d_occ", i), 32'(oc[0]), 32'(tbl[i].e_occ));
      check($sformatf("vec%0d_bubble", i), 32'(bc[0]), 32'(tbl[i].e_bub));
      if (tbl[i].e_ov)
        check($sformatf("vec%0d_out_data", i), 32'(od[0]), 32'(tbl[i].e_od));
    end

    // Flush while full with a new entry offered
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h11, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h12, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h13, 1'b0, 1'b0);
    check("flush_pre_occ", 32'(oc[0]), 2);
    check("flush_pre_in_ready", 32'(ir[0]), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("flush_occ", 32'(oc[0]), 0);
    check("flush_out_valid", 32'(ov[0]), 0);
    check("flush_in_ready", 32'(ir[0]), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("flush_not_captured", 32'(oc[0]), 0);

    // Halt entry drains, then blocks accepts; flush keeps the flag
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h21, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h22, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h23, 1'b0, 1'b1);
    check("halt_out_halt", 32'(oh[0]), 1);
    check("halt_out_data", 32'(od[0]), 32'h21);
    check("halt_not_yet", 32'(hl[0]), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h24, 1'b0, 1'b1);
    check("halt_set", 32'(hl[0]), 1);
    check("halt_in_ready", 32'(ir[0]), 0);
    check("halt_drain_valid", 32'(ov[0]), 1);
    check("halt_drain_data", 32'(od[0]), 32'h22);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h25, 1'b0, 1'b0);
    check("halt_empty_ready", 32'(ir[0]), 0);
    check("halt_empty_occ", 32'(oc[0]), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h26, 1'b0, 1'b0);
    check("halt_after_flush", 32'(hl[0]), 1);
    check("halt_after_flush_ready", 32'(ir[0]), 0);

    // Bubble saturation and reset clearing
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("bub_reset", 32'(bc[0]), 0);
    check("bub_halt_cleared", 32'(hl[0]), 0);
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("bub_saturate", 32'(bc[0]), 32'hF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check("bub_cleared", 32'(bc[0]), 0);

    // Halt entry flushed before it dequeues
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h41, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("halt_flushed_occ", 32'(oc[0]), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("halt_flushed_flag", 32'(hl[0]), 0);

    // Reset in the middle of a transfer
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h51, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h52, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("midrst_occ", 32'(oc[0]), 0);
    check("midrst_out_valid", 32'(ov[0]), 0);

    // Single-entry build: same-cycle replace without a bubble
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h31, 1'b0, 1'b0);
    check("single_first_ready", 32'(ir[1]), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h32, 1'b0, 1'b1);
    check("single_replace_ready", 32'(ir[1]), 1);
    check("single_head_valid", 32'(ov[1]), 1);
    check("single_head_data", 32'(od[1]), 32'h31);
    check("single_head_occ", 32'(oc[1]), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h33, 1'b0, 1'b0);
    check("single_new_valid", 32'(ov[1]), 1);
    check("single_new_data", 32'(od[1]), 32'h32);
    check("single_new_occ", 32'(oc[1]), 1);
    check("single_no_bubble", 32'(bc[1]), 0);
    check("single_full_ready", 32'(ir[1]), 0);

    // Random segments against the queue model
    for (int seg = 0; seg < 4; seg++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        mc[k] = 0; mh[k] = 1'b0; mbub[k] = 0; mst[k] = 1'b0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
        logic e, f, o;
        e = ($urandom_range(0, 9) != 0);
        f = e && ($urandom_range(0, 32) == 0);
        o = f ? 1'b0 : ($urandom_range(0, 9) < 6);
        drive(1'b1, e, f, ($urandom_range(0, 9) < 6), 16'($urandom),
              ($urandom_range(0, 49) == 0), o);
        for (int k = 0; k < 2; k++) begin
          bit e_ov, e_ir;
          e_ov = en && mc[k] > 0;
          if (k == 0) e_ir = en && !flush && !mh[k] && mst[k] && mc[k] < 2;
          else        e_ir = en && !flush && !mh[k] && (mc[k] == 0 || out_ready);
          check($sformatf("rnd%0d_in_ready", k), 32'(ir[k]), 32'(e_ir));
          check($sformatf("rnd%0d_out_valid", k), 32'(ov[k]), 32'(e_ov));
          check($sformatf("rnd%0d_occ", k), 32'(oc[k]), 32'(mc[k]));
          check($sformatf("rnd%0d_halted", k), 32'(hl[k]), 32'(mh[k]));
          check($sformatf("rnd%0d_bubble", k), 32'(bc[k]), 32'(mbub[k]));
          if (e_ov) begin
            check($sformatf("rnd%0d_out_data", k), 32'(od[k]), 32'(mb[k][0][15:0]));
            check($sformatf("rnd%0d_out_halt", k), 32'(oh[k]), 32'(mb[k][0][16]));
          end
          m_ov[k]  = e_ov;
          m_acc[k] = in_valid && e_ir;
          m_deq[k] = e_ov && out_ready && !flush;
        end
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
          if (en) begin
            if (out_ready && !m_ov[k] && mbub[k] < 15) mbub[k]++;
            if (flush) begin
              mc[k] = 0;
            end else begin
              if (m_deq[k]) begin
                if (mb[k][0][16]) mh[k] = 1'b1;
                mb[k][0] = mb[k][1];
                mc[k]--;
              end
              if (m_acc[k]) begin
                mb[k][mc[k]] = {in_halt, in_data};
                mc[k]++;
              end
            end
            mst[k] = 1'b1;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
